// File: rtl/pico_mips_pkg.sv
// Shared types and constants for the pico-MIPS fetch path.
package pico_mips_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_RESET = 0;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the RUN state: halt > wait > jump > branch > increment.
module pc_next_calc
  import pico_mips_pkg::*;
#(
  parameter int AddrSz   = 6,
  parameter int OffsetSz = 6
) (
  input  logic [AddrSz-1:0]   pc,
  input  logic                jump,
  input  logic [AddrSz-1:0]   jump_target,
  input  logic                branch_taken,
  input  logic [OffsetSz-1:0] branch_offset,
  input  logic                wait_req,
  input  logic                in_valid,
  input  logic                halt_req,
  output logic [AddrSz-1:0]   next_pc,
  output fetch_state_t        next_state,
  output logic                take_input
);

  logic [AddrSz-1:0] offset_ext;

  // Sign-extend the offset; the adder below wraps modulo 2^AddrSz.
  assign offset_ext = AddrSz'($signed(branch_offset));

  always_comb begin
    next_pc    = pc + AddrSz'(1);
    next_state = RUN;
    take_input = 1'b0;
    if (halt_req) begin
      next_pc    = pc;
      next_state = HALT;
    end else if (wait_req) begin
      if (in_valid) begin
        take_input = 1'b1;
      end else begin
        next_pc    = pc;
        next_state = WAIT;
      end
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = pc + offset_ext;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch FSM for pico-MIPS: run, wait on external input, halt.
module fetch_sequencer
  import pico_mips_pkg::*;
#(
  parameter int AddrSz   = 6,
  parameter int OffsetSz = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                jump,
  input  logic [AddrSz-1:0]   jump_target,
  input  logic                branch_taken,
  input  logic [OffsetSz-1:0] branch_offset,
  input  logic                wait_req,
  input  logic                in_valid,
  input  logic                halt_req,
  output logic [AddrSz-1:0]   pc,
  output logic                instr_valid,
  output logic                in_ack,
  output logic                waiting,
  output logic                halted
);

  fetch_state_t      state;
  fetch_state_t      run_next_state;
  logic [AddrSz-1:0] run_next_pc;
  logic              run_take_input;

  pc_next_calc #(
    .AddrSz  (AddrSz),
    .OffsetSz(OffsetSz)
  ) u_pc_next_calc (
    .pc           (pc),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .wait_req     (wait_req),
    .in_valid     (in_valid),
    .halt_req     (halt_req),
    .next_pc      (run_next_pc),
    .next_state   (run_next_state),
    .take_input   (run_take_input)
  );

  // in_ack is a registered single-cycle pulse; it is cleared every cycle unless an input is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      pc     <= AddrSz'(PC_RESET);
      in_ack <= 1'b0;
    end else begin
      in_ack <= 1'b0;
      case (state)
        RUN: begin
          if (!stall) begin
            pc     <= run_next_pc;
            state  <= run_next_state;
            in_ack <= run_take_input;
          end
        end
        WAIT: begin
          if (in_valid) begin
            pc     <= pc + AddrSz'(1);
            in_ack <= 1'b1;
            state  <= RUN;
          end
        end
        HALT: begin
        end
        default: state <= RUN;
      endcase
    end
  end

  assign instr_valid = (state == RUN) && !stall;
  assign waiting     = (state == WAIT);
  assign halted      = (state == HALT);

endmodule
